// File: rtl/hazard_forward_tracker.sv
// Tracks destination tags of in-flight instructions from EX to WB and derives
// per-operand forwarding selects for EX plus the load-use stall for ID.
module hazard_forward_tracker #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int AW      = 5,
    parameter int SEL_W   = $clog2(DEPTH),
    parameter int RS_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [NUM_SRC*AW-1:0]    id_rs,
    input  logic [NUM_SRC-1:0]       id_rs_used,
    input  logic [AW-1:0]            id_rd,
    input  logic                     id_reg_write,
    input  logic [RS_W-1:0]          id_ready_stage,
    input  logic                     flush,
    output logic                     stall,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic                     fwd_err,
    output logic [31:0]              stall_count
);

    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DEPTH-1:0]           wr_q, wr_d;
    logic [DEPTH-1:0][AW-1:0]   rd_q, rd_d;
    logic [DEPTH-1:0][RS_W-1:0] rdy_q, rdy_d;
    logic [NUM_SRC*AW-1:0]      ex_rs_q, ex_rs_d;
    logic [NUM_SRC-1:0]         ex_used_q, ex_used_d;
    logic [31:0]                stall_count_q, stall_count_d;

    logic [DEPTH-1:0]   producer;
    logic [NUM_SRC-1:0] op_err;
    logic [NUM_SRC-1:0] op_stall;
    logic               load_ex;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            producer[k] = valid_q[k] && wr_q[k] && (rd_q[k] != '0);
        end
    end

    // Scanning oldest to youngest lets the youngest matching producer win.
    always_comb begin
        fwd_sel = '0;
        op_err  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (valid_q[0] && ex_used_q[i] && (ex_rs_q[i*AW +: AW] != '0)) begin
                for (int k = DEPTH - 1; k >= 1; k--) begin
                    if (producer[k] && (rd_q[k] == ex_rs_q[i*AW +: AW])) begin
                        fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                        op_err[i]                 = (k < int'(rdy_q[k]));
                    end
                end
            end
        end
        fwd_err = |op_err;
    end

    // Only the youngest match decides, so an older ready copy cannot hide it.
    always_comb begin
        op_stall = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_valid && id_rs_used[i] && (id_rs[i*AW +: AW] != '0)) begin
                for (int k = DEPTH - 2; k >= 0; k--) begin
                    if (producer[k] && (rd_q[k] == id_rs[i*AW +: AW])) begin
                        op_stall[i] = ((k + 1) < int'(rdy_q[k]));
                    end
                end
            end
        end
        stall = (|op_stall) && !flush;
    end

    always_comb begin
        load_ex   = id_valid && !stall && !flush;
        valid_d   = {valid_q[DEPTH-2:0], load_ex};
        wr_d      = {wr_q[DEPTH-2:0], load_ex && id_reg_write};
        rd_d      = {rd_q[DEPTH-2:0], (load_ex ? id_rd : {AW{1'b0}})};
        rdy_d     = {rdy_q[DEPTH-2:0], (load_ex ? id_ready_stage : {RS_W{1'b0}})};
        ex_rs_d   = load_ex ? id_rs : '0;
        ex_used_d = load_ex ? id_rs_used : '0;
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            rdy_q         <= '0;
            ex_rs_q       <= '0;
            ex_used_q     <= '0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            rdy_q         <= rdy_d;
            ex_rs_q       <= ex_rs_d;
            ex_used_q     <= ex_used_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_tracker.sv
// Self-checking bench: hand-derived vector table for the pipeline scenarios,
// randomized traffic against an issue-history model, and a wider instance.
module tb_hazard_forward_tracker;

    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic [1:0]  id_ready_stage;
    logic        flush;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic        fwd_err;
    logic [31:0] stall_count;

    logic        v4;
    logic [14:0] rs4;
    logic [2:0]  used4;
    logic [4:0]  rd4;
    logic        wr4;
    logic [1:0]  rdy4;
    logic        fl4;
    logic        stall4;
    logic [5:0]  sel4;
    logic        err4;
    logic [31:0] cnt4;

    hazard_forward_tracker #(.NUM_SRC(2), .DEPTH(DEPTH), .AW(5), .RS_W(2)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_ready_stage(id_ready_stage), .flush(flush), .stall(stall),
        .fwd_sel(fwd_sel), .fwd_err(fwd_err), .stall_count(stall_count)
    );

    hazard_forward_tracker #(.NUM_SRC(3), .DEPTH(4), .AW(5), .RS_W(2)) dut4 (
        .clk(clk), .reset(reset), .id_valid(v4), .id_rs(rs4),
        .id_rs_used(used4), .id_rd(rd4), .id_reg_write(wr4),
        .id_ready_stage(rdy4), .flush(fl4), .stall(stall4),
        .fwd_sel(sel4), .fwd_err(err4), .stall_count(cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       wr;
        logic [1:0] rdy;
        logic       fl;
        logic       chk;
        logic       e_stall;
        logic [1:0] e_sel0;
        logic [1:0] e_sel1;
        logic       e_err;
        int         e_cnt;
    } vec_t;

    typedef struct {
        int         t;
        logic [4:0] rd;
        logic       wr;
        int         rdy;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
    } instr_t;

    vec_t        tbl[$];
    instr_t      issued[$];
    int          cyc;
    logic [31:0] m_cnt;
    int          checks;
    int          errors;

    function automatic vec_t mk(input logic rst, input logic v, input int rs0, input int rs1,
                                input int used, input int rd, input logic wr, input int rdy,
                                input logic fl, input logic chk, input logic es, input int s0,
                                input int s1, input logic ee, input int ec);
        vec_t r;
        r.rst = rst; r.v = v; r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.used = 2'(used);
        r.rd = 5'(rd); r.wr = wr; r.rdy = 2'(rdy); r.fl = fl; r.chk = chk;
        r.e_stall = es; r.e_sel0 = 2'(s0); r.e_sel1 = 2'(s1); r.e_err = ee; r.e_cnt = ec;
        return r;
    endfunction

    // Youngest producer of tag whose current stage lies in [lo, hi], or -1.
    function automatic int youngest(input logic [4:0] tag, input int lo, input int hi,
                                    output int rdy);
        int best;
        best = -1;
        rdy  = 0;
        foreach (issued[j]) begin
            int st;
            st = cyc - issued[j].t - 1;
            if (st >= lo && st <= hi && issued[j].wr && issued[j].rd != 5'd0 &&
                issued[j].rd == tag && (best < 0 || st < best)) begin
                best = st;
                rdy  = issued[j].rdy;
            end
        end
        return best;
    endfunction

    task automatic modelEval(output logic es, output logic [3:0] esel, output logic ee);
        int s;
        int r;
        logic [4:0] tag;
        es = 1'b0; esel = 4'd0; ee = 1'b0;
        foreach (issued[j]) begin
            if (cyc - issued[j].t - 1 == 0) begin
                for (int i = 0; i < 2; i++) begin
                    tag = (i == 0) ? issued[j].rs0 : issued[j].rs1;
                    if (issued[j].used[i] && tag != 5'd0) begin
                        s = youngest(tag, 1, DEPTH - 1, r);
                        if (s >= 0) begin
                            esel[i*2 +: 2] = 2'(s);
                            if (s < r) ee = 1'b1;
                        end
                    end
                end
            end
        end
        if (id_valid && !flush) begin
            for (int i = 0; i < 2; i++) begin
                tag = (i == 0) ? id_rs[4:0] : id_rs[9:5];
                if (id_rs_used[i] && tag != 5'd0) begin
                    s = youngest(tag, 0, DEPTH - 2, r);
                    if (s >= 0 && s + 1 < r) es = 1'b1;
                end
            end
        end
    endtask

    task automatic modelUpdate(input logic es);
        instr_t n;
        if (reset) begin
            issued.delete();
            m_cnt = 32'd0;
        end else begin
            if (es && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (id_valid && !es && !flush) begin
                n.t = cyc; n.rd = id_rd; n.wr = id_reg_write; n.rdy = int'(id_ready_stage);
                n.rs0 = id_rs[4:0]; n.rs1 = id_rs[9:5]; n.used = id_rs_used;
                issued.push_back(n);
            end
        end
        cyc++;
        while (issued.size() > 0 && cyc - issued[0].t - 1 >= DEPTH) void'(issued.pop_front());
    endtask

    task automatic applyStimulus(input vec_t v);
        reset          = v.rst;
        id_valid       = v.v;
        id_rs          = {v.rs1, v.rs0};
        id_rs_used     = v.used;
        id_rd          = v.rd;
        id_reg_write   = v.wr;
        id_ready_stage = v.rdy;
        flush          = v.fl;
    endtask

    task automatic checkVal(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic checkOutput(input string nm, input logic es, input logic [3:0] esel,
                               input logic ee, input logic [31:0] ec);
        checkVal({nm, ".stall"}, {31'd0, stall}, {31'd0, es});
        checkVal({nm, ".fwd_sel"}, {28'd0, fwd_sel}, {28'd0, esel});
        checkVal({nm, ".fwd_err"}, {31'd0, fwd_err}, {31'd0, ee});
        checkVal({nm, ".stall_count"}, stall_count, ec);
    endtask

    // One clock: drive, settle, compare (table or model), clock, advance model.
    task automatic runCycle(input vec_t v, input bit use_table, input string nm);
        logic       es;
        logic [3:0] esel;
        logic       ee;
        applyStimulus(v);
        #2;
        modelEval(es, esel, ee);
        if (use_table) begin
            if (v.chk) checkOutput(nm, v.e_stall, {v.e_sel1, v.e_sel0}, v.e_err, 32'(v.e_cnt));
        end else begin
            checkOutput(nm, es, esel, ee, m_cnt);
        end
        @(posedge clk);
        #1;
        modelUpdate(es);
    endtask

    initial begin
        vec_t rv;
        checks = 0; errors = 0; cyc = 0; m_cnt = 32'd0;
        v4 = 1'b0; rs4 = '0; used4 = '0; rd4 = '0; wr4 = 1'b0; rdy4 = '0; fl4 = 1'b0;

        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        // ALU chain: add x5 then sub reading x5
        tbl.push_back(mk(0,1,0,0,0,5,1,1,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,5,6,3,8,1,1,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0));
        // Load-use on x7
        tbl.push_back(mk(0,1,0,0,0,7,1,2,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,7,0,1,10,1,1,0, 1,1,0,0,0,0));
        tbl.push_back(mk(0,1,7,0,1,10,1,1,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,2,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
        // Double write of x3, consumer reads x3 on operand 1
        tbl.push_back(mk(0,1,0,0,0,3,1,1,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,1,0,0,0,3,1,1,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,1,4,3,3,11,1,1,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
        // Load into x0, consumer reads x0
        tbl.push_back(mk(0,1,0,0,0,0,1,2,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,1,0,0,3,12,0,1,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
        // Load x9, consumer flushed in the would-be stall cycle
        tbl.push_back(mk(0,1,0,0,0,9,1,2,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,1,9,0,1,13,1,1,1, 1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
        // Reset while the load sits in EX and the consumer is stalled
        tbl.push_back(mk(0,1,0,0,0,7,1,2,0, 1,0,0,0,0,1));
        tbl.push_back(mk(1,1,7,0,1,10,1,1,0, 1,1,0,0,0,1));
        tbl.push_back(mk(0,1,7,0,1,10,1,1,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0));
        // Ready stage 3 equals DEPTH: stall until the producer retires
        tbl.push_back(mk(0,1,0,0,0,20,1,3,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,1,20,0,1,21,0,1,0, 1,1,0,0,0,0));
        tbl.push_back(mk(0,1,20,0,1,21,0,1,0, 1,1,0,0,0,1));
        tbl.push_back(mk(0,1,20,0,1,21,0,1,0, 1,0,0,0,0,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,2));

        foreach (tbl[n]) runCycle(tbl[n], 1'b1, $sformatf("vec%0d", n));

        for (int n = 0; n < 300; n++) begin
            rv = mk(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                    ($urandom_range(0, 7) == 0), 1, 0, 0, 0, 0, 0);
            runCycle(rv, 1'b0, $sformatf("rand%0d", n));
        end

        // Wide instance: third operand matches a producer at stage 3
        reset = 1'b0; id_valid = 1'b0; flush = 1'b0;
        v4 = 1'b1; rd4 = 5'd6; wr4 = 1'b1; rdy4 = 2'd1; used4 = 3'b000; rs4 = '0;
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        v4 = 1'b1; rs4 = {5'd6, 5'd2, 5'd1}; used4 = 3'b111; rd4 = 5'd0; wr4 = 1'b0;
        #2;
        checkVal("w4.stall", {31'd0, stall4}, 32'd0);
        @(posedge clk); #1;
        v4 = 1'b0;
        #2;
        checkVal("w4.fwd_sel", {26'd0, sel4}, 32'h30);
        checkVal("w4.fwd_err", {31'd0, err4}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
